// File: rtl/fpu_fma_pkg.sv
// Shared encodings and types for the FMA scheduler: recoded operand widths,
// rounding modes, FMA commands and the in-flight tracker entry layout.
package fpu_fma_pkg;
  localparam int FLEN_REC  = 33;
  localparam int EXC_W     = 5;
  localparam int NUM_REQ   = 2;
  localparam int TAG_W_DEF = 5;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [1:0] FMA_CMD_MADD  = 2'b00;
  localparam logic [1:0] FMA_CMD_MSUB  = 2'b01;
  localparam logic [1:0] FMA_CMD_NMSUB = 2'b10;
  localparam logic [1:0] FMA_CMD_NMADD = 2'b11;

  typedef struct packed {
    logic                 v;
    logic                 id;
    logic [TAG_W_DEF-1:0] tag;
  } trk_entry_t;

  // DYN defers to fcsr.frm; reserved encodings (5,6) pass through untouched.
  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction
endpackage

// File: rtl/fma_inflight_tracker.sv
// Tracks ops across the fixed FMA latency; the head stage lines up with the
// pipe's result outputs. Flush masks entries of a requester combinationally.
module fma_inflight_tracker
  import fpu_fma_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_v,
  input  logic             in_id,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [1:0]       flush,
  output logic             head_v,
  output logic             head_id,
  output logic [TAG_W-1:0] head_tag,
  output logic             busy
);
  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0]            vld_live;
  logic [LATENCY-1:0]            id_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;

  always_comb begin
    vld_live = '0;
    for (int k = 0; k < LATENCY; k++)
      vld_live[k] = vld_pipe[k] & ~flush[id_pipe[k]];
  end

  // Stage k holds an op issued k+1 cycles ago, so stage LATENCY-1 meets fma_out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_v & ~flush[in_id];
      id_pipe[0]  <= in_id;
      tag_pipe[0] <= in_tag;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe[k] <= vld_live[k-1];
        id_pipe[k]  <= id_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign head_v   = vld_live[LATENCY-1];
  assign head_id  = id_pipe[LATENCY-1];
  assign head_tag = tag_pipe[LATENCY-1];
  assign busy     = |vld_pipe;
endmodule

// File: rtl/fpu_fma_sched.sv
// Round-robin two-requester issue scheduler in front of the SP FMA pipe, with
// dynamic rounding resolution, result steering by tag and per-requester flush.
module fpu_fma_sched
  import fpu_fma_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          frm,
  input  logic                hold,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_ren3,
  input  logic                req0_swap23,
  input  logic [2:0]          req0_rm,
  input  logic [1:0]          req0_fmaCmd,
  input  logic [FLEN_REC-1:0] req0_in1,
  input  logic [FLEN_REC-1:0] req0_in2,
  input  logic [FLEN_REC-1:0] req0_in3,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_ren3,
  input  logic                req1_swap23,
  input  logic [2:0]          req1_rm,
  input  logic [1:0]          req1_fmaCmd,
  input  logic [FLEN_REC-1:0] req1_in1,
  input  logic [FLEN_REC-1:0] req1_in2,
  input  logic [FLEN_REC-1:0] req1_in3,
  input  logic [TAG_W-1:0]    req1_tag,
  input  logic                flush0,
  input  logic                flush1,
  output logic                fma_in_valid,
  output logic                fma_in_ren3,
  output logic                fma_in_swap23,
  output logic [2:0]          fma_in_rm,
  output logic [1:0]          fma_in_fmaCmd,
  output logic [FLEN_REC-1:0] fma_in_in1,
  output logic [FLEN_REC-1:0] fma_in_in2,
  output logic [FLEN_REC-1:0] fma_in_in3,
  input  logic [FLEN_REC-1:0] fma_out_data,
  input  logic [EXC_W-1:0]    fma_out_exc,
  output logic                resp0_valid,
  output logic [TAG_W-1:0]    resp0_tag,
  output logic [FLEN_REC-1:0] resp0_data,
  output logic [EXC_W-1:0]    resp0_exc,
  output logic                resp1_valid,
  output logic [TAG_W-1:0]    resp1_tag,
  output logic [FLEN_REC-1:0] resp1_data,
  output logic [EXC_W-1:0]    resp1_exc,
  output logic                busy
);
  logic             ptr;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic [TAG_W-1:0] gnt_tag;
  logic             head_v, head_id;
  logic [TAG_W-1:0] head_tag;

  // Reset gates eligibility so ready/issue stay low while reset is held.
  assign elig0  = reset & req0_valid & ~flush0 & ~hold;
  assign elig1  = reset & req1_valid & ~flush1 & ~hold;
  assign grant0 = elig0 & (~elig1 | ~ptr);
  assign grant1 = elig1 & (~elig0 |  ptr);

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign fma_in_valid = grant0 | grant1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                ptr <= 1'b0;
    else if (grant0 | grant1)  ptr <= ~grant1;
  end

  // Without a grant the fields follow requester 0.
  always_comb begin
    fma_in_ren3   = req0_ren3;
    fma_in_swap23 = req0_swap23;
    fma_in_rm     = resolve_rm(req0_rm, frm);
    fma_in_fmaCmd = req0_fmaCmd;
    fma_in_in1    = req0_in1;
    fma_in_in2    = req0_in2;
    fma_in_in3    = req0_in3;
    gnt_tag       = req0_tag;
    if (grant1) begin
      fma_in_ren3   = req1_ren3;
      fma_in_swap23 = req1_swap23;
      fma_in_rm     = resolve_rm(req1_rm, frm);
      fma_in_fmaCmd = req1_fmaCmd;
      fma_in_in1    = req1_in1;
      fma_in_in2    = req1_in2;
      fma_in_in3    = req1_in3;
      gnt_tag       = req1_tag;
    end
  end

  fma_inflight_tracker #(.LATENCY(LATENCY), .TAG_W(TAG_W)) u_trk (
    .clock    (clock),
    .reset    (reset),
    .in_v     (fma_in_valid),
    .in_id    (grant1),
    .in_tag   (gnt_tag),
    .flush    ({flush1, flush0}),
    .head_v   (head_v),
    .head_id  (head_id),
    .head_tag (head_tag),
    .busy     (busy)
  );

  assign resp0_valid = head_v & ~head_id;
  assign resp1_valid = head_v &  head_id;
  assign resp0_tag   = head_tag;
  assign resp1_tag   = head_tag;
  assign resp0_data  = fma_out_data;
  assign resp1_data  = fma_out_data;
  assign resp0_exc   = fma_out_exc;
  assign resp1_exc   = fma_out_exc;
endmodule

// File: tb/tb_fpu_fma_sched.sv
// Directed bench for fpu_fma_sched with LATENCY=3, TAG_W=5.
module tb_fpu_fma_sched;
  import fpu_fma_pkg::*;

  logic        clock, reset, hold;
  logic [2:0]  frm;
  logic        req0_valid, req0_ready, req0_ren3, req0_swap23;
  logic [2:0]  req0_rm;
  logic [1:0]  req0_fmaCmd;
  logic [32:0] req0_in1, req0_in2, req0_in3;
  logic [4:0]  req0_tag;
  logic        req1_valid, req1_ready, req1_ren3, req1_swap23;
  logic [2:0]  req1_rm;
  logic [1:0]  req1_fmaCmd;
  logic [32:0] req1_in1, req1_in2, req1_in3;
  logic [4:0]  req1_tag;
  logic        flush0, flush1;
  logic        fma_in_valid, fma_in_ren3, fma_in_swap23;
  logic [2:0]  fma_in_rm;
  logic [1:0]  fma_in_fmaCmd;
  logic [32:0] fma_in_in1, fma_in_in2, fma_in_in3;
  logic [32:0] fma_out_data;
  logic [4:0]  fma_out_exc;
  logic        resp0_valid, resp1_valid, busy;
  logic [4:0]  resp0_tag, resp1_tag, resp0_exc, resp1_exc;
  logic [32:0] resp0_data, resp1_data;

  int chk = 0;
  int pass = 0;

  fpu_fma_sched #(.LATENCY(3), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .frm(frm), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ren3(req0_ren3),
    .req0_swap23(req0_swap23), .req0_rm(req0_rm), .req0_fmaCmd(req0_fmaCmd),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_in3(req0_in3), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ren3(req1_ren3),
    .req1_swap23(req1_swap23), .req1_rm(req1_rm), .req1_fmaCmd(req1_fmaCmd),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_in3(req1_in3), .req1_tag(req1_tag),
    .flush0(flush0), .flush1(flush1),
    .fma_in_valid(fma_in_valid), .fma_in_ren3(fma_in_ren3), .fma_in_swap23(fma_in_swap23),
    .fma_in_rm(fma_in_rm), .fma_in_fmaCmd(fma_in_fmaCmd),
    .fma_in_in1(fma_in_in1), .fma_in_in2(fma_in_in2), .fma_in_in3(fma_in_in3),
    .fma_out_data(fma_out_data), .fma_out_exc(fma_out_exc),
    .resp0_valid(resp0_valid), .resp0_tag(resp0_tag), .resp0_data(resp0_data), .resp0_exc(resp0_exc),
    .resp1_valid(resp1_valid), .resp1_tag(resp1_tag), .resp1_data(resp1_data), .resp1_exc(resp1_exc),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr_inputs;
    hold = 0; frm = 0; flush0 = 0; flush1 = 0;
    req0_valid = 0; req0_ren3 = 0; req0_swap23 = 0; req0_rm = 0; req0_fmaCmd = 0;
    req0_in1 = 0; req0_in2 = 0; req0_in3 = 0; req0_tag = 0;
    req1_valid = 0; req1_ren3 = 0; req1_swap23 = 0; req1_rm = 0; req1_fmaCmd = 0;
    req1_in1 = 0; req1_in2 = 0; req1_in3 = 0; req1_tag = 0;
    fma_out_data = 0; fma_out_exc = 0;
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 2 later.
  task automatic cyc;
    @(posedge clock); #2;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    clr_inputs(); reset = 0;
    req0_valid = 1; req1_valid = 1;
    #7;
    chk++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got %b want 0", req0_ready); else pass++;
    chk++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1 got %b want 0", req1_ready); else pass++;
    chk++; if (fma_in_valid !== 1'b0) $display("FAIL rst_fma_in_valid got %b want 0", fma_in_valid); else pass++;
    chk++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
      $display("FAIL rst_resp_valid got %b%b want 00", resp1_valid, resp0_valid); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass++;
    req0_valid = 0; req1_valid = 0;
    cyc(); cyc(); reset = 1;
  endtask

  task automatic test_single;
    cyc(); req0_valid = 1; req0_rm = RM_RNE; req0_tag = 5'h0A;
    req0_in1 = 33'h0_3F800000; req0_in2 = 33'h0_40000000; req0_fmaCmd = FMA_CMD_MSUB; settle();
    chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL single_grant got %b%b want 01", req1_ready, req0_ready); else pass++;
    chk++; if (fma_in_valid !== 1'b1) $display("FAIL single_issue got %b want 1", fma_in_valid); else pass++;
    chk++; if (fma_in_in1 !== 33'h0_3F800000 || fma_in_in2 !== 33'h0_40000000)
      $display("FAIL single_operands got %h %h want 03f800000 040000000", fma_in_in1, fma_in_in2); else pass++;
    chk++; if (fma_in_rm !== RM_RNE || fma_in_fmaCmd !== FMA_CMD_MSUB)
      $display("FAIL single_rm_cmd got %h %h want 0 1", fma_in_rm, fma_in_fmaCmd); else pass++;
    cyc(); req0_valid = 0; settle();
    chk++; if (busy !== 1'b1 || fma_in_valid !== 1'b0)
      $display("FAIL single_busy got busy=%b issue=%b want 1 0", busy, fma_in_valid); else pass++;
    cyc(); settle();
    chk++; if (resp0_valid !== 1'b0) $display("FAIL single_early got %b want 0", resp0_valid); else pass++;
    cyc(); fma_out_data = 33'h0_40400000; fma_out_exc = 5'h01; settle();
    chk++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0)
      $display("FAIL single_resp_valid got %b%b want 01", resp1_valid, resp0_valid); else pass++;
    chk++; if (resp0_tag !== 5'h0A || resp0_data !== 33'h0_40400000 || resp0_exc !== 5'h01)
      $display("FAIL single_resp_fields got %h %h %h want 0a 040400000 01", resp0_tag, resp0_data, resp0_exc); else pass++;
    cyc(); settle();
    chk++; if (resp0_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_drain got valid=%b busy=%b want 0 0", resp0_valid, busy); else pass++;
  endtask

  task automatic test_rm;
    cyc(); req1_valid = 1; req1_rm = RM_DYN; frm = RM_RDN; req1_tag = 5'h03; req1_ren3 = 1; settle();
    chk++; if (req1_ready !== 1'b1 || fma_in_rm !== 3'b010)
      $display("FAIL rm_dyn got ready=%b rm=%b want 1 010", req1_ready, fma_in_rm); else pass++;
    chk++; if (fma_in_ren3 !== 1'b1 || fma_in_swap23 !== 1'b0)
      $display("FAIL rm_ren3 got %b %b want 1 0", fma_in_ren3, fma_in_swap23); else pass++;
    cyc(); req1_rm = RM_RMM; req1_ren3 = 0; req1_swap23 = 1; settle();
    chk++; if (fma_in_rm !== 3'b100 || fma_in_swap23 !== 1'b1)
      $display("FAIL rm_static got rm=%b swap=%b want 100 1", fma_in_rm, fma_in_swap23); else pass++;
    cyc(); req1_rm = 3'b101; req1_swap23 = 0; settle();
    chk++; if (fma_in_rm !== 3'b101) $display("FAIL rm_reserved got %b want 101", fma_in_rm); else pass++;
    cyc(); req1_valid = 0; frm = 0;
    repeat (4) cyc();
  endtask

  task automatic test_back_to_back;
    logic exp_id [0:5];
    logic [4:0] exp_tag [0:5];
    logic g;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i < 6) begin
        req0_valid = 1; req1_valid = 1;
        req0_tag = 5'(8'h10 + i); req1_tag = 5'(8'h18 + i);
      end else begin
        req0_valid = 0; req1_valid = 0;
      end
      fma_out_data = 33'h1_0000_0000 | 33'(i);
      settle();
      if (i < 6) begin
        g = (i % 2 == 1);
        exp_id[i] = g;
        exp_tag[i] = g ? 5'(8'h18 + i) : 5'(8'h10 + i);
        chk++; if (req0_ready !== ~g || req1_ready !== g)
          $display("FAIL b2b_grant[%0d] got %b%b want %b%b", i, req1_ready, req0_ready, g, ~g); else pass++;
      end
      if (i >= 3 && i < 9) begin
        chk++; if (resp0_valid !== ~exp_id[i-3] || resp1_valid !== exp_id[i-3])
          $display("FAIL b2b_resp_valid[%0d] got %b%b want %b%b", i, resp1_valid, resp0_valid,
                   exp_id[i-3], ~exp_id[i-3]); else pass++;
        chk++; if ((exp_id[i-3] ? resp1_tag : resp0_tag) !== exp_tag[i-3] ||
                   (exp_id[i-3] ? resp1_data : resp0_data) !== (33'h1_0000_0000 | 33'(i)))
          $display("FAIL b2b_resp_tag[%0d] got %h/%h want %h", i, resp0_tag, resp1_tag, exp_tag[i-3]); else pass++;
      end
      if (i == 9) begin
        chk++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy); else pass++;
      end
    end
  endtask

  task automatic test_flush;
    cyc(); req0_valid = 1; req0_tag = 5'd1; settle();
    chk++; if (req0_ready !== 1'b1) $display("FAIL flush_issue1 got %b want 1", req0_ready); else pass++;
    cyc(); req0_tag = 5'd2; settle();
    chk++; if (req0_ready !== 1'b1) $display("FAIL flush_issue2 got %b want 1", req0_ready); else pass++;
    cyc(); req0_valid = 0; req1_valid = 1; req1_tag = 5'd3; settle();
    chk++; if (req1_ready !== 1'b1) $display("FAIL flush_issue3 got %b want 1", req1_ready); else pass++;
    cyc(); req1_valid = 0; req0_valid = 1; req0_tag = 5'd4; flush0 = 1; settle();
    chk++; if (req0_ready !== 1'b0 || fma_in_valid !== 1'b0)
      $display("FAIL flush_same_cycle got ready=%b issue=%b want 0 0", req0_ready, fma_in_valid); else pass++;
    chk++; if (resp0_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL flush_head got resp0=%b busy=%b want 0 1", resp0_valid, busy); else pass++;
    cyc(); req0_valid = 0; flush0 = 0; settle();
    chk++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
      $display("FAIL flush_killed got %b%b want 00", resp1_valid, resp0_valid); else pass++;
    cyc(); settle();
    chk++; if (resp1_valid !== 1'b1 || resp1_tag !== 5'd3 || resp0_valid !== 1'b0)
      $display("FAIL flush_survivor got v=%b%b tag=%h want 10 03", resp1_valid, resp0_valid, resp1_tag); else pass++;
    cyc(); settle();
    chk++; if (busy !== 1'b0 || resp1_valid !== 1'b0)
      $display("FAIL flush_idle got busy=%b resp1=%b want 0 0", busy, resp1_valid); else pass++;
  endtask

  task automatic test_flush_both;
    cyc(); req0_valid = 1; req0_tag = 5'd6; settle();
    chk++; if (req0_ready !== 1'b1) $display("FAIL fb_issue got %b want 1", req0_ready); else pass++;
    cyc(); req0_tag = 5'd7; req1_valid = 1; req1_tag = 5'd9; flush1 = 1; settle();
    chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL fb_other_unaffected got %b%b want 01", req1_ready, req0_ready); else pass++;
    cyc(); flush0 = 1; flush1 = 1; settle();
    chk++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || fma_in_valid !== 1'b0)
      $display("FAIL fb_no_grant got %b%b issue=%b want 00 0", req1_ready, req0_ready, fma_in_valid); else pass++;
    chk++; if (busy !== 1'b1) $display("FAIL fb_busy_hold got %b want 1", busy); else pass++;
    cyc(); flush0 = 0; flush1 = 0; req0_valid = 0; req1_tag = 5'd10; settle();
    chk++; if (busy !== 1'b0 || resp0_valid !== 1'b0)
      $display("FAIL fb_cleared got busy=%b resp0=%b want 0 0", busy, resp0_valid); else pass++;
    chk++; if (req1_ready !== 1'b1) $display("FAIL fb_reissue got %b want 1", req1_ready); else pass++;
    cyc(); req1_valid = 0;
    repeat (4) cyc();
  endtask

  task automatic test_hold;
    for (int i = 0; i < 4; i++) begin
      cyc(); hold = 1; req0_valid = 1; req1_valid = 1; settle();
      chk++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || fma_in_valid !== 1'b0)
        $display("FAIL hold[%0d] got %b%b issue=%b want 00 0", i, req1_ready, req0_ready, fma_in_valid); else pass++;
    end
    cyc(); hold = 0; settle();
    chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL hold_release got %b%b want 01", req1_ready, req0_ready); else pass++;
    cyc(); settle();
    chk++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      $display("FAIL hold_next got %b%b want 10", req1_ready, req0_ready); else pass++;
    cyc(); req0_valid = 0; req1_valid = 0;
    repeat (4) cyc();
  endtask

  task automatic test_async_reset;
    cyc(); req0_valid = 1; req0_tag = 5'h11;
    cyc(); req0_valid = 0; req1_valid = 1; req1_tag = 5'h12;
    cyc(); req1_valid = 0; req0_valid = 1; req0_tag = 5'h13; settle();
    chk++; if (busy !== 1'b1) $display("FAIL ar_busy_before got %b want 1", busy); else pass++;
    #1; reset = 0; #1;
    chk++; if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
      $display("FAIL ar_immediate got busy=%b resp=%b%b want 0 00", busy, resp1_valid, resp0_valid); else pass++;
    chk++; if (req0_ready !== 1'b0 || fma_in_valid !== 1'b0)
      $display("FAIL ar_no_grant got ready=%b issue=%b want 0 0", req0_ready, fma_in_valid); else pass++;
    req0_valid = 0;
    cyc(); cyc(); reset = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL ar_after[%0d] got resp=%b%b busy=%b want 00 0", i, resp1_valid, resp0_valid, busy); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rm();
    test_back_to_back();
    test_flush();
    test_flush_both();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
